id_ex_skid: RTL and testbench
=============================

# id_ex_skid

Parametrised ID→EX pipeline stage with a valid/ready handshake and a two-entry skid buffer. It sits between the decode and execute stages. It replaces the single-register hold/clear stage with:
- a stall that keeps the held instruction instead of discarding it,
- a separate flush that inserts a bubble,
- full throughput under back-pressure, with no combinational ready path.

It also counts bubbles presented to execute, for performance monitoring.

## Interface
Parameters:
- XLEN, 32, width of inst_addr, rs1_data and rs2_data.
- RD_W, 5, width of the destination register address.
- NOP_INST, 32'h0000_0013, instruction word driven when the stage holds no valid entry (addi x0,x0,0).
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush from ctrl; highest priority.
- in_valid_i  in  1  decode presents an instruction.
- in_ready_o  out  1  stage can accept. Driven from registered state only.
- inst_i  in  32  instruction word.
- inst_addr_i  in  XLEN  instruction address.
- rs1_data_i  in  XLEN  operand 1.
- rs2_data_i  in  XLEN  operand 2.
- rd_addr_i  in  RD_W  destination register.
- rd_wen_i  in  1  register write enable.
- out_valid_o  out  1  execute is presented a valid instruction.
- out_ready_i  in  1  execute consumes the presented instruction.
- inst_o, inst_addr_o, rs1_data_o, rs2_data_o, rd_addr_o, rd_wen_o  out  as inputs  presented payload.
- bubble_cnt_o  out  CNT_W  saturating count of bubble cycles.

## Operation
- Storage:
  - main register M drives all outputs;
  - skid register S;
  - state EMPTY / ONE / TWO.
- Handshake terms:
  - accept = in_valid_i & in_ready_o;
  - drain = out_valid_o & out_ready_i.
- Register outputs:
  - in_ready_o = (state != TWO);
  - out_valid_o = (state != EMPTY).
- Transitions when flush_i = 0:
  - EMPTY, accept → ONE, M ← in.
  - EMPTY, no accept → EMPTY.
  - ONE, accept & drain → ONE, M ← in.
  - ONE, accept & !drain → TWO, S ← in, M unchanged.
  - ONE, !accept & drain → EMPTY, M ← bubble.
  - ONE, neither → ONE, M held.
  - TWO, drain → ONE, M ← S, S ← bubble.
  - TWO, no drain → TWO, M and S held. Accept is impossible in TWO.
- Bubble payload: inst = NOP_INST, rd_wen = 0, all other fields 0. Whenever out_valid_o = 0, outputs show the bubble.
- Flush (flush_i = 1), regardless of state, valid or ready:
  - state ← EMPTY; M and S ← bubble;
  - an instruction handshaken the same cycle is discarded;
  - no drain is credited to M's old contents beyond what execute already sampled.
- Ordering is strict FIFO. S is never presented before M.
- Bubble counter: increments when out_valid_o = 0 & out_ready_i = 1. It saturates at all-ones, with no wrap. Flush does not clear it; only reset does.

## Timing
- Reset values (asynchronous):
  - state EMPTY;
  - in_ready_o = 1, out_valid_o = 0;
  - inst_o = NOP_INST, rd_wen_o = 0;
  - inst_addr_o, rs1_data_o, rs2_data_o, rd_addr_o = 0;
  - bubble_cnt_o = 0.
- Reset deassertion mid-stream: the first accept is possible in the first cycle after rst_n rises.
- Latency: 1 cycle. An instruction accepted at edge N is on the outputs with out_valid_o = 1 after edge N.
- Throughput: 1 instruction/cycle while out_ready_i = 1. in_ready_o never drops while out_ready_i is held high.
- Back-pressure:
  - out_ready_i falling while ONE with in_valid_i high: that cycle's input goes to S, and in_ready_o = 0 from the next cycle.
  - in_ready_o returns to 1 one cycle after the first drain in TWO.
- in_ready_o and out_valid_o have no combinational path from any input.
- Flush is seen on outputs one cycle later: out_valid_o = 0, inst_o = NOP_INST.
- Simultaneous flush and accept/drain: flush wins.

## Test plan
- Reset, then stream 4 instructions with out_ready_i = 1 (inst_addr 0x0, 0x4, 0x8, 0xC) → outputs in order one cycle after each accept; in_ready_o stays 1; bubble_cnt_o = 1 (cycle before the first arrives).
- Back-pressure: accept A, B with out_ready_i = 0 → state TWO, in_ready_o = 0, outputs hold A. Raise out_ready_i → A, then B on consecutive cycles; in_ready_o = 1 one cycle after A drains.
- Flush while TWO with in_valid_i = 1 → next cycle out_valid_o = 0, inst_o = 32'h0000_0013, rd_wen_o = 0, in_ready_o = 1; that input and S are lost.
- Async reset asserted mid-cycle while ONE → outputs at reset values immediately, without a clock edge.
- Counter saturation (CNT_W = 4): 20 idle cycles with out_ready_i = 1 → bubble_cnt_o = 4'hF and holds.
- Random valid/ready toggling over 10k cycles against a FIFO scoreboard → no loss, no duplication, no reordering; out_valid_o is never 1 with rd_wen_o from a flushed entry.

Source files
------------

// File: rtl/id_ex_skid.sv
// id_ex_skid: ID->EX pipeline stage with valid/ready handshake, two-entry skid buffer
// and a saturating counter of bubble cycles presented to execute.
module id_ex_skid #(
    parameter int          XLEN     = 32,
    parameter int          RD_W     = 5,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       inst_i,
    input  logic [XLEN-1:0]   inst_addr_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [RD_W-1:0]   rd_addr_i,
    input  logic              rd_wen_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       inst_o,
    output logic [XLEN-1:0]   inst_addr_o,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic [RD_W-1:0]   rd_addr_o,
    output logic              rd_wen_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);
    localparam int PW = 32 + 3 * XLEN + RD_W + 1;
    localparam logic [PW-1:0] BUBBLE = {NOP_INST, {(PW - 32){1'b0}}};

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t          state, state_d;
    logic [PW-1:0]   m, s, m_d, s_d, din;
    logic [CNT_W-1:0] cnt;
    logic            accept, drain;

    assign din          = {inst_i, inst_addr_i, rs1_data_i, rs2_data_i, rd_addr_i, rd_wen_i};
    assign in_ready_o   = state != TWO;
    assign out_valid_o  = state != EMPTY;
    assign accept       = in_valid_i & in_ready_o;
    assign drain        = out_valid_o & out_ready_i;
    assign {inst_o, inst_addr_o, rs1_data_o, rs2_data_o, rd_addr_o, rd_wen_o} = m;
    assign bubble_cnt_o = cnt;

    // M is reloaded with the bubble on every path into EMPTY, so outputs need no masking
    always_comb begin
        state_d = state;
        m_d     = m;
        s_d     = s;
        if (flush_i) begin
            state_d = EMPTY;
            m_d     = BUBBLE;
            s_d     = BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    state_d = accept ? ONE : EMPTY;
                    m_d     = accept ? din : m;
                end
                ONE: begin
                    state_d = accept ? (drain ? ONE : TWO) : (drain ? EMPTY : ONE);
                    m_d     = accept ? (drain ? din : m) : (drain ? BUBBLE : m);
                    s_d     = (accept && !drain) ? din : s;
                end
                TWO: begin
                    state_d = drain ? ONE : TWO;
                    m_d     = drain ? s : m;
                    s_d     = drain ? BUBBLE : s;
                end
                default: begin
                    state_d = EMPTY;
                    m_d     = BUBBLE;
                    s_d     = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            m     <= BUBBLE;
            s     <= BUBBLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            m     <= m_d;
            s     <= s_d;
            if (!out_valid_o && out_ready_i && !(&cnt))
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_ex_skid.sv
// tb_id_ex_skid: randomized and directed checks of id_ex_skid against a queue-based model
// of the stage contents and a saturating bubble count.
module tb_id_ex_skid;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        wen;
    } pl_t;

    logic clk, rst_n, flush_i, in_valid_i, out_ready_i;
    logic in_ready_o, out_valid_o, in_ready4, out_valid4;
    pl_t  din, dout, dout4, bub;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
    logic [31:0] i4_inst, i4_addr, i4_rs1, i4_rs2;
    logic [4:0]  i4_rd;
    logic        i4_wen;
    logic [31:0] o_inst, o_addr, o_rs1, o_rs2;
    logic [4:0]  o_rd;
    logic        o_wen;

    pl_t q[$];
    int unsigned m16, m4;
    int errs, checks;

    id_ex_skid dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(din.inst), .inst_addr_i(din.addr), .rs1_data_i(din.rs1),
        .rs2_data_i(din.rs2), .rd_addr_i(din.rd), .rd_wen_i(din.wen),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .inst_o(o_inst), .inst_addr_o(o_addr), .rs1_data_o(o_rs1),
        .rs2_data_o(o_rs2), .rd_addr_o(o_rd), .rd_wen_o(o_wen),
        .bubble_cnt_o(cnt16)
    );

    id_ex_skid #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready4),
        .inst_i(din.inst), .inst_addr_i(din.addr), .rs1_data_i(din.rs1),
        .rs2_data_i(din.rs2), .rd_addr_i(din.rd), .rd_wen_i(din.wen),
        .out_valid_o(out_valid4), .out_ready_i(out_ready_i),
        .inst_o(i4_inst), .inst_addr_o(i4_addr), .rs1_data_o(i4_rs1),
        .rs2_data_o(i4_rs2), .rd_addr_o(i4_rd), .rd_wen_o(i4_wen),
        .bubble_cnt_o(cnt4)
    );

    assign dout  = {o_inst, o_addr, o_rs1, o_rs2, o_rd, o_wen};
    assign dout4 = {i4_inst, i4_addr, i4_rs1, i4_rs2, i4_rd, i4_wen};

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic pl_t rand_pl();
        pl_t p;
        p.inst = $urandom;
        p.addr = $urandom;
        p.rs1  = $urandom;
        p.rs2  = $urandom;
        p.rd   = 5'($urandom);
        p.wen  = 1'($urandom);
        return p;
    endfunction

    function automatic pl_t exp_pl();
        return (q.size() > 0) ? q[0] : bub;
    endfunction

    // The stage is a 2-deep FIFO: present head, drain head, then append if room
    task automatic model_edge();
        bit v = q.size() > 0;
        bit r = q.size() < 2;
        if (!v && out_ready_i) begin
            if (m16 < 65535) m16++;
            if (m4 < 15) m4++;
        end
        if (flush_i) q.delete();
        else begin
            if (v && out_ready_i) void'(q.pop_front());
            if (in_valid_i && r) q.push_back(din);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_ready_o, out_valid_o} !== 2'b10) begin
            errs++; $display("FAIL reset_handshake: got %b required 10", {in_ready_o, out_valid_o});
        end
        checks++;
        if (dout !== bub) begin
            errs++; $display("FAIL reset_payload: got %h required %h", dout, bub);
        end
        checks++;
        if (cnt16 !== 16'd0) begin
            errs++; $display("FAIL reset_cnt: got %0d required 0", cnt16);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_stream();
        pl_t p;
        out_ready_i = 1;
        in_valid_i  = 1;
        for (int i = 0; i < 4; i++) begin
            p = rand_pl();
            p.addr = 32'(i * 4);
            din = p;
            tick();
            checks++;
            if (!out_valid_o || !in_ready_o || dout !== p) begin
                errs++;
                $display("FAIL stream_%0d: got v=%b r=%b %h required v=1 r=1 %h",
                         i, out_valid_o, in_ready_o, dout, p);
            end
        end
        checks++;
        if (cnt16 !== 16'd1) begin
            errs++; $display("FAIL stream_bubble_cnt: got %0d required 1", cnt16);
        end
        in_valid_i = 0;
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || dout !== bub) begin
            errs++; $display("FAIL stream_drain: got v=%b %h required v=0 %h", out_valid_o, dout, bub);
        end
        out_ready_i = 0;
    endtask

    task automatic test_backpressure();
        pl_t a, b;
        a = rand_pl();
        b = rand_pl();
        out_ready_i = 0;
        in_valid_i  = 1;
        din = a;
        tick();
        din = b;
        tick();
        checks++;
        if (in_ready_o !== 1'b0 || !out_valid_o || dout !== a) begin
            errs++; $display("FAIL bp_full: got r=%b v=%b %h required r=0 v=1 %h", in_ready_o, out_valid_o, dout, a);
        end
        in_valid_i  = 0;
        out_ready_i = 1;
        tick();
        checks++;
        if (in_ready_o !== 1'b1 || !out_valid_o || dout !== b) begin
            errs++; $display("FAIL bp_second: got r=%b v=%b %h required r=1 v=1 %h", in_ready_o, out_valid_o, dout, b);
        end
        tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            errs++; $display("FAIL bp_empty: got v=%b required 0", out_valid_o);
        end
        out_ready_i = 0;
    endtask

    task automatic test_flush();
        out_ready_i = 0;
        in_valid_i  = 1;
        for (int i = 0; i < 2; i++) begin
            din = rand_pl();
            din.wen = 1;
            tick();
        end
        checks++;
        if (in_ready_o !== 1'b0) begin
            errs++; $display("FAIL flush_setup: got r=%b required 0", in_ready_o);
        end
        flush_i = 1;
        din = rand_pl();
        din.wen = 1;
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || o_inst !== 32'h0000_0013 || o_wen !== 1'b0 || in_ready_o !== 1'b1) begin
            errs++;
            $display("FAIL flush_bubble: got v=%b inst=%h wen=%b r=%b required v=0 inst=00000013 wen=0 r=1",
                     out_valid_o, o_inst, o_wen, in_ready_o);
        end
        flush_i = 0;
        in_valid_i = 0;
        out_ready_i = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid_o !== 1'b0 || dout !== bub) begin
                errs++; $display("FAIL flush_lost_%0d: got v=%b %h required v=0 %h", i, out_valid_o, dout, bub);
            end
        end
        out_ready_i = 0;
    endtask

    task automatic test_async_reset();
        in_valid_i = 1;
        din = rand_pl();
        din.wen = 1;
        tick();
        in_valid_i = 0;
        checks++;
        if (out_valid_o !== 1'b1) begin
            errs++; $display("FAIL areset_setup: got v=%b required 1", out_valid_o);
        end
        #2;
        rst_n = 0;
        q.delete();
        m16 = 0;
        m4 = 0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || dout !== bub || cnt16 !== 16'd0) begin
            errs++;
            $display("FAIL areset_immediate: got v=%b r=%b %h cnt=%0d required v=0 r=1 %h cnt=0",
                     out_valid_o, in_ready_o, dout, cnt16, bub);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_saturation();
        out_ready_i = 1;
        in_valid_i  = 0;
        repeat (20) tick();
        checks++;
        if (cnt4 !== 4'hF || cnt16 !== 16'd20) begin
            errs++; $display("FAIL sat_reach: got cnt4=%h cnt16=%0d required cnt4=f cnt16=20", cnt4, cnt16);
        end
        repeat (3) tick();
        checks++;
        if (cnt4 !== 4'hF) begin
            errs++; $display("FAIL sat_hold: got %h required f", cnt4);
        end
        out_ready_i = 0;
    endtask

    task automatic test_random();
        pl_t e;
        for (int c = 0; c < 10000; c++) begin
            in_valid_i  = $urandom_range(0, 3) != 0;
            out_ready_i = (c % 500 < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            flush_i     = $urandom_range(0, 49) == 0;
            din         = rand_pl();
            tick();
            e = exp_pl();
            checks++;
            if (out_valid_o !== (q.size() > 0) || in_ready_o !== (q.size() < 2) || dout !== e) begin
                errs++;
                $display("FAIL rand_out@%0d: got v=%b r=%b %h required v=%b r=%b %h",
                         c, out_valid_o, in_ready_o, dout, q.size() > 0, q.size() < 2, e);
            end
            checks++;
            if (cnt16 !== 16'(m16) || cnt4 !== 4'(m4)) begin
                errs++; $display("FAIL rand_cnt@%0d: got %0d/%0d required %0d/%0d", c, cnt16, cnt4, m16, m4);
            end
            checks++;
            if (out_valid4 !== (q.size() > 0) || in_ready4 !== (q.size() < 2) || dout4 !== e) begin
                errs++; $display("FAIL rand_out4@%0d: got v=%b %h required %h", c, out_valid4, dout4, e);
            end
        end
        flush_i = 0;
        in_valid_i = 0;
        out_ready_i = 0;
    endtask

    initial begin
        errs = 0;
        checks = 0;
        m16 = 0;
        m4 = 0;
        bub = '0;
        bub.inst = 32'h0000_0013;
        rst_n = 0;
        flush_i = 0;
        in_valid_i = 0;
        out_ready_i = 0;
        din = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
